ebpc_stream_merger: RTL and testbench

Downstream stage of `ebpc_encoder`: merges the encoder's independent ZNZ (zero/non-zero) and BPC output streams into one framed `DATA_W`-bit stream for the off-chip or memory link. Each stream is buffered in its own FIFO, cut into bursts of up to `MAX_BURST` words, and each burst is preceded by a header word carrying the stream ID and burst length. A flush input drains partial bursts and marks the final word with `last_o`.

---
 rtl/ebpc_pkg.sv | 23 ++
 rtl/ebpc_sync_fifo.sv | 65 ++++++
 rtl/ebpc_stream_merger.sv | 181 ++++++++++++++++++
 tb/tb_ebpc_stream_merger.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebpc_pkg.sv
// Shared types and header layout for the EBPC stream merger.
package ebpc_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } merger_state_t;

  typedef enum logic {
    ZNZ = 1'b0,
    BPC = 1'b1
  } stream_id_t;

  // Header word: stream ID in the MSB, burst length minus one below it.
  localparam int unsigned HDR_ID_POS  = DATA_W - 1;
  localparam int unsigned HDR_ID_W    = 1;
  localparam int unsigned HDR_LEN_LSB = 0;
  localparam int unsigned HDR_LEN_W   = DATA_W - HDR_ID_W;

endpackage

// File: rtl/ebpc_sync_fifo.sv
// Single-clock FIFO with a registered fill count; overflowing pushes and
// underflowing pops are ignored.
module ebpc_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     fill_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              do_push, do_pop;

  assign full_o  = (fill_q == FILL_W'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ebpc_stream_merger.sv
// Merges the ZNZ and BPC encoder streams into one framed stream of
// header-prefixed bursts, with a flush that drains partial bursts.
module ebpc_stream_merger
  import ebpc_pkg::*;
#(
  parameter int unsigned DATA_W     = ebpc_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] znz_data_i,
  input  logic              znz_vld_i,
  output logic              znz_rdy_o,
  input  logic [DATA_W-1:0] bpc_data_i,
  input  logic              bpc_vld_i,
  output logic              bpc_rdy_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              last_o,
  output logic              idle_o
);

  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;
  // Header layout keeps the package's ID width and scales the length field with DATA_W.
  localparam int unsigned ID_POS = HDR_ID_POS + DATA_W - ebpc_pkg::DATA_W;
  localparam int unsigned LEN_W  = DATA_W - (ebpc_pkg::DATA_W - HDR_LEN_W);

  logic [DATA_W-1:0] znz_head, bpc_head;
  logic [FILL_W-1:0] znz_fill, bpc_fill, sel_fill;
  logic              znz_full, bpc_full, znz_empty, bpc_empty;
  logic              znz_push, bpc_push, znz_pop, bpc_pop;
  logic              znz_elig, bpc_elig, other_empty, body_last_word;

  merger_state_t     state_q, state_d;
  stream_id_t        sel_q, sel_d;
  stream_id_t        last_served_q, last_served_d;
  logic [LEN_W-1:0]  len_m1_q, len_m1_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              flush_pending_q, flush_pending_d;

  function automatic logic [LEN_W-1:0] burst_len_m1(input logic [FILL_W-1:0] fill);
    if (fill >= FILL_W'(MAX_BURST)) return LEN_W'(MAX_BURST - 1);
    return LEN_W'(fill - FILL_W'(1));
  endfunction

  ebpc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_znz_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (znz_push),
    .data_i  (znz_data_i),
    .pop_i   (znz_pop),
    .data_o  (znz_head),
    .full_o  (znz_full),
    .empty_o (znz_empty),
    .fill_o  (znz_fill)
  );

  ebpc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_bpc_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bpc_push),
    .data_i  (bpc_data_i),
    .pop_i   (bpc_pop),
    .data_o  (bpc_head),
    .full_o  (bpc_full),
    .empty_o (bpc_empty),
    .fill_o  (bpc_fill)
  );

  assign znz_rdy_o = !znz_full && !flush_pending_q;
  assign bpc_rdy_o = !bpc_full && !flush_pending_q;
  assign znz_push  = znz_vld_i && znz_rdy_o;
  assign bpc_push  = bpc_vld_i && bpc_rdy_o;

  assign znz_elig = (znz_fill >= FILL_W'(MAX_BURST)) || (flush_pending_q && !znz_empty);
  assign bpc_elig = (bpc_fill >= FILL_W'(MAX_BURST)) || (flush_pending_q && !bpc_empty);

  assign znz_pop = (state_q == BODY) && rdy_i && (sel_q == ZNZ);
  assign bpc_pop = (state_q == BODY) && rdy_i && (sel_q == BPC);

  assign sel_fill       = (sel_q == ZNZ) ? znz_fill : bpc_fill;
  assign other_empty    = (sel_q == ZNZ) ? bpc_empty : znz_empty;
  assign body_last_word = (state_q == BODY) && (cnt_q == len_m1_q);

  // Inputs are stalled while a flush is pending, so this stays stable under back-pressure.
  assign last_o = body_last_word && flush_pending_q && (sel_fill == FILL_W'(1)) && other_empty;

  assign idle_o = (state_q == IDLE) && znz_empty && bpc_empty && !flush_pending_q;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    len_m1_d      = len_m1_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    unique case (state_q)
      IDLE: begin
        if (znz_elig || bpc_elig) begin
          if (znz_elig && bpc_elig) begin
            sel_d = (last_served_q == ZNZ) ? BPC : ZNZ;
          end else begin
            sel_d = znz_elig ? ZNZ : BPC;
          end
          len_m1_d = burst_len_m1((sel_d == ZNZ) ? znz_fill : bpc_fill);
          state_d  = HDR;
        end
      end
      HDR: begin
        if (rdy_i) begin
          state_d = BODY;
          cnt_d   = '0;
        end
      end
      BODY: begin
        if (rdy_i) begin
          if (cnt_q == len_m1_q) begin
            state_d       = IDLE;
            last_served_d = sel_q;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_pending_d = flush_pending_q;
    if (!flush_pending_q) begin
      if (flush_i) flush_pending_d = 1'b1;
    end else if ((last_o && rdy_i) || ((state_q == IDLE) && znz_empty && bpc_empty)) begin
      flush_pending_d = 1'b0;
    end
  end

  always_comb begin
    data_o = '0;
    vld_o  = 1'b0;
    unique case (state_q)
      HDR: begin
        vld_o                = 1'b1;
        data_o[ID_POS]       = sel_q;
        data_o[LEN_W-1:0]    = len_m1_q;
      end
      BODY: begin
        vld_o  = 1'b1;
        data_o = (sel_q == ZNZ) ? znz_head : bpc_head;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      sel_q           <= ZNZ;
      last_served_q   <= BPC;
      len_m1_q        <= '0;
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sel_q           <= sel_d;
      last_served_q   <= last_served_d;
      len_m1_q        <= len_m1_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

endmodule

// File: tb/tb_ebpc_stream_merger.sv
// Scoreboard bench: drivers queue expected stream words and headers, an independent
// monitor parses the framed output and checks it against those queues.
module tb_ebpc_stream_merger;
  import ebpc_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned FD = 16;
  localparam int unsigned MB = 8;

  typedef logic [DW-1:0] word_q_t[$];

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [DW-1:0] znz_data_i, bpc_data_i, data_o;
  logic          znz_vld_i, znz_rdy_o, bpc_vld_i, bpc_rdy_o;
  logic          flush_i, vld_o, rdy_i, last_o, idle_o;

  always #5 clk_i = ~clk_i;

  ebpc_stream_merger #(
    .DATA_W     (DW),
    .FIFO_DEPTH (FD),
    .MAX_BURST  (MB)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .znz_data_i (znz_data_i),
    .znz_vld_i  (znz_vld_i),
    .znz_rdy_o  (znz_rdy_o),
    .bpc_data_i (bpc_data_i),
    .bpc_vld_i  (bpc_vld_i),
    .bpc_rdy_o  (bpc_rdy_o),
    .flush_i    (flush_i),
    .data_o     (data_o),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .last_o     (last_o),
    .idle_o     (idle_o)
  );

  // Scoreboard state shared between stimulus and monitor.
  logic [DW-1:0] znz_q[$];
  logic [DW-1:0] bpc_q[$];
  logic [DW-1:0] hdr_q[$];
  int            total = 0;
  int            bad = 0;
  bit            in_body = 0;
  bit            cur_id = 0;
  int            body_left = 0;
  bit            flush_mode = 0;
  bit            rdy_rand = 0;
  int            stall_left = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic word_q_t seq(input logic [DW-1:0] base, input int n);
    word_q_t q;
    for (int i = 0; i < n; i++) q.push_back(base + DW'(i));
    return q;
  endfunction

  function automatic word_q_t rnd(input int n);
    word_q_t q;
    for (int i = 0; i < n; i++) q.push_back(DW'($urandom));
    return q;
  endfunction

  // Output back-pressure: either always ready, or random 0-3 cycle stalls.
  initial begin
    rdy_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (!rdy_rand) begin
        rdy_i = 1'b1;
      end else if (stall_left > 0) begin
        rdy_i = 1'b0;
        stall_left--;
      end else begin
        rdy_i = 1'b1;
        stall_left = int'($urandom_range(0, 3));
      end
    end
  end

  // Monitor: parses header/body framing and checks against the scoreboard.
  initial begin
    bit            prev_stall;
    logic [DW-1:0] prev_data, exp_w;
    logic          prev_last;
    bit            exp_last;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_stall = 0;
        in_body    = 0;
      end else begin
        if (prev_stall) begin
          chk(vld_o == 1'b1, "stall_vld_hold", int'(vld_o), 1);
          chk(data_o == prev_data, "stall_data_hold", int'(data_o), int'(prev_data));
          chk(last_o == prev_last, "stall_last_hold", int'(last_o), int'(prev_last));
        end
        if (vld_o && rdy_i) begin
          if (!in_body) begin
            if (hdr_q.size() > 0) begin
              exp_w = hdr_q.pop_front();
              chk(data_o == exp_w, "header", int'(data_o), int'(exp_w));
            end else begin
              chk(int'(data_o[DW-2:0]) == MB - 1, "header_full_len", int'(data_o), MB - 1);
            end
            chk(last_o == 1'b0, "header_last", int'(last_o), 0);
            cur_id    = data_o[DW-1];
            body_left = int'(data_o[DW-2:0]) + 1;
            chk((cur_id ? bpc_q.size() : znz_q.size()) >= body_left, "header_len_avail",
                cur_id ? bpc_q.size() : znz_q.size(), body_left);
            in_body = 1;
          end else begin
            if (cur_id ? (bpc_q.size() > 0) : (znz_q.size() > 0)) begin
              exp_w = cur_id ? bpc_q.pop_front() : znz_q.pop_front();
              chk(data_o == exp_w, cur_id ? "bpc_body" : "znz_body", int'(data_o), int'(exp_w));
            end else begin
              chk(0, "body_underflow", int'(data_o), -1);
            end
            body_left--;
            exp_last = flush_mode && (body_left == 0) && (znz_q.size() == 0) &&
                       (bpc_q.size() == 0);
            chk(last_o == exp_last, "body_last", int'(last_o), int'(exp_last));
            if (body_left == 0) in_body = 0;
          end
        end
        prev_stall = vld_o && !rdy_i;
        prev_data  = data_o;
        prev_last  = last_o;
      end
    end
  end

  // Drive one stream word by word; a word is queued as expected once accepted.
  task automatic drive(input bit id, input word_q_t words, input bit gaps);
    foreach (words[i]) begin
      int g;
      int c;
      bit hs;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      if (id) bpc_vld_i = 1'b0;
      else    znz_vld_i = 1'b0;
      repeat (g) begin
        @(posedge clk_i);
        #1;
      end
      if (id) begin
        bpc_data_i = words[i];
        bpc_vld_i  = 1'b1;
      end else begin
        znz_data_i = words[i];
        znz_vld_i  = 1'b1;
      end
      hs = 0;
      c  = 0;
      while (!hs && c < 3000) begin
        @(negedge clk_i);
        hs = id ? bpc_rdy_o : znz_rdy_o;
        @(posedge clk_i);
        #1;
        c++;
      end
      if (!hs) chk(0, "input_accept_timeout", c, 3000);
      else if (id) bpc_q.push_back(words[i]);
      else znz_q.push_back(words[i]);
    end
    if (id) bpc_vld_i = 1'b0;
    else    znz_vld_i = 1'b0;
  endtask

  task automatic wait_q(input int zn, input int bp, input string name);
    int c;
    c = 0;
    while (!(znz_q.size() == zn && bpc_q.size() == bp && hdr_q.size() == 0 && !in_body)
           && c < 3000) begin
      @(negedge clk_i);
      c++;
    end
    chk(c < 3000, name, c, 3000);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int c;
    znz_vld_i  = 1'b0;
    bpc_vld_i  = 1'b0;
    znz_data_i = '0;
    bpc_data_i = '0;
    flush_i    = 1'b0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk(vld_o == 1'b0, "rst_vld", int'(vld_o), 0);
    chk(data_o == '0, "rst_data", int'(data_o), 0);
    chk(last_o == 1'b0, "rst_last", int'(last_o), 0);
    chk(idle_o == 1'b1, "rst_idle", int'(idle_o), 1);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    chk(znz_rdy_o == 1'b1, "rst_znz_rdy", int'(znz_rdy_o), 1);
    chk(bpc_rdy_o == 1'b1, "rst_bpc_rdy", int'(bpc_rdy_o), 1);
    @(posedge clk_i);
    #1;

    // Simultaneous fill: ZNZ wins the first tie.
    hdr_q.push_back(8'h07);
    hdr_q.push_back(8'h87);
    fork
      drive(1'b0, seq(8'h20, 8), 1'b0);
      drive(1'b1, seq(8'h30, 8), 1'b0);
    join
    wait_q(0, 0, "tie_first_drain");

    // Single ZNZ burst.
    hdr_q.push_back(8'h07);
    drive(1'b0, seq(8'h01, 8), 1'b0);
    wait_q(0, 0, "znz_single_drain");

    // ZNZ was served last, so BPC wins this tie.
    hdr_q.push_back(8'h87);
    hdr_q.push_back(8'h07);
    fork
      drive(1'b0, seq(8'h40, 8), 1'b0);
      drive(1'b1, seq(8'h50, 8), 1'b0);
    join
    wait_q(0, 0, "tie_alt_drain");

    // Partial BPC burst drained by flush.
    drive(1'b1, seq(8'hA0, 3), 1'b0);
    repeat (3) begin
      @(negedge clk_i);
      chk(vld_o == 1'b0, "partial_no_burst", int'(vld_o), 0);
    end
    @(posedge clk_i);
    #1;
    hdr_q.push_back(8'h82);
    flush_mode = 1;
    pulse_flush();
    @(negedge clk_i);
    chk(bpc_rdy_o == 1'b0, "flush_bpc_stall", int'(bpc_rdy_o), 0);
    chk(znz_rdy_o == 1'b0, "flush_znz_stall", int'(znz_rdy_o), 0);
    @(posedge clk_i);
    #1;
    wait_q(0, 0, "flush3_drain");
    flush_mode = 0;
    @(negedge clk_i);
    chk(bpc_rdy_o == 1'b1, "post_flush_rdy", int'(bpc_rdy_o), 1);
    chk(idle_o == 1'b1, "post_flush_idle", int'(idle_o), 1);
    @(posedge clk_i);
    #1;

    // Flush with nothing buffered.
    flush_mode = 1;
    pulse_flush();
    @(negedge clk_i);
    chk(znz_rdy_o == 1'b0, "empty_flush_pending", int'(znz_rdy_o), 0);
    chk(vld_o == 1'b0, "empty_flush_vld0", int'(vld_o), 0);
    @(negedge clk_i);
    chk(idle_o == 1'b1, "empty_flush_idle", int'(idle_o), 1);
    repeat (3) begin
      @(negedge clk_i);
      chk(vld_o == 1'b0, "empty_flush_vld", int'(vld_o), 0);
    end
    flush_mode = 0;
    @(posedge clk_i);
    #1;

    // Random data and output stalls; 25 BPC words leave one behind for the flush.
    rdy_rand = 1;
    fork
      drive(1'b0, rnd(40), 1'b1);
      drive(1'b1, rnd(25), 1'b1);
    join
    wait_q(0, 1, "rand_full_bursts");
    hdr_q.push_back(8'h80);
    flush_mode = 1;
    pulse_flush();
    wait_q(0, 0, "rand_flush_drain");
    flush_mode = 0;
    rdy_rand   = 0;
    @(negedge clk_i);
    chk(idle_o == 1'b1, "rand_end_idle", int'(idle_o), 1);
    @(posedge clk_i);
    #1;

    // Asynchronous reset in the middle of a body.
    hdr_q.push_back(8'h07);
    drive(1'b0, seq(8'h60, 8), 1'b0);
    c = 0;
    while (znz_q.size() > 5 && c < 500) begin
      @(negedge clk_i);
      c++;
    end
    chk(c < 500, "reach_body", c, 500);
    #3 rst_ni = 1'b0;
    #1;
    chk(vld_o == 1'b0, "async_rst_vld", int'(vld_o), 0);
    chk(idle_o == 1'b1, "async_rst_idle", int'(idle_o), 1);
    znz_q.delete();
    bpc_q.delete();
    hdr_q.delete();
    in_body = 0;
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    hdr_q.push_back(8'h07);
    drive(1'b0, seq(8'h01, 8), 1'b0);
    wait_q(0, 0, "post_reset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
